// File: rtl/key_entry_if.sv
// Keyboard-decoder to calculator-datapath bundle for the key entry sequencer.
interface key_entry_if;
    logic [8:0]   last_change;
    logic [511:0] key_down;
    logic         key_valid;
    logic [3:0]   left_tens;
    logic [3:0]   left_ones;
    logic [3:0]   right_tens;
    logic [3:0]   right_ones;
    logic [1:0]   op;
    logic [2:0]   phase;
    logic         result_valid;
    logic         key_err;

    modport master (
        output last_change, key_down, key_valid,
        input  left_tens, left_ones, right_tens, right_ones, op, phase, result_valid, key_err
    );

    modport slave (
        input  last_change, key_down, key_valid,
        output left_tens, left_ones, right_tens, right_ones, op, phase, result_valid, key_err
    );
endinterface

// File: rtl/key_entry_sequencer.sv
// Turns PS/2 make events into a two-digit operand / operator / operand / Enter sequence.
// Optional Backspace step-back is enabled by defining KEY_ENTRY_BACKSPACE_EN.
module key_entry_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    key_entry_if.slave  bus
);
    localparam int CW = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;

    typedef enum logic [2:0] {
        S_L1 = 3'd0, S_L2 = 3'd1, S_OP = 3'd2, S_R1 = 3'd3,
        S_R2 = 3'd4, S_EQ = 3'd5, S_SHOW = 3'd6, S_UNUSED = 3'd7
    } state_t;

    state_t        state_r, state_n;
    logic [3:0]    left_tens_r, left_ones_r, right_tens_r, right_ones_r;
    logic [3:0]    left_tens_n, left_ones_n, right_tens_n, right_ones_n;
    logic [1:0]    op_r, op_n;
    logic          result_valid_r, key_err_r, key_err_n, key_valid_d_r;
    logic [CW-1:0] idle_cnt_r;
    logic          evt_s, timeout_s, clear_s;
    logic          digit_ok_s, op_ok_s, enter_s, esc_s;
    logic [3:0]    digit_s;
    logic [1:0]    op_code_s;
`ifdef KEY_ENTRY_BACKSPACE_EN
    logic          bksp_s;
`endif

    // Rising edge of the decoder strobe while the key is held down: breaks and repeats are filtered.
    assign evt_s = bus.key_valid & ~key_valid_d_r & bus.key_down[bus.last_change];
    assign timeout_s = (TIMEOUT_CYCLES != 32'd0) && !evt_s && (state_r != S_L1) &&
                       (idle_cnt_r == CW'(TIMEOUT_CYCLES - 32'd1));

    // Key class decode from the latest scan code.
    always_comb begin
        digit_ok_s = 1'b0;
        digit_s    = 4'd0;
        op_ok_s    = 1'b0;
        op_code_s  = 2'b11;
        enter_s    = 1'b0;
        esc_s      = 1'b0;
`ifdef KEY_ENTRY_BACKSPACE_EN
        bksp_s     = 1'b0;
`endif
        case (bus.last_change)
            9'h045, 9'h070: begin digit_ok_s = 1'b1; digit_s = 4'd0; end
            9'h016, 9'h069: begin digit_ok_s = 1'b1; digit_s = 4'd1; end
            9'h01E, 9'h072: begin digit_ok_s = 1'b1; digit_s = 4'd2; end
            9'h026, 9'h07A: begin digit_ok_s = 1'b1; digit_s = 4'd3; end
            9'h025, 9'h06B: begin digit_ok_s = 1'b1; digit_s = 4'd4; end
            9'h02E, 9'h073: begin digit_ok_s = 1'b1; digit_s = 4'd5; end
            9'h036, 9'h074: begin digit_ok_s = 1'b1; digit_s = 4'd6; end
            9'h03D, 9'h06C: begin digit_ok_s = 1'b1; digit_s = 4'd7; end
            9'h03E, 9'h075: begin digit_ok_s = 1'b1; digit_s = 4'd8; end
            9'h046, 9'h07D: begin digit_ok_s = 1'b1; digit_s = 4'd9; end
            9'h079:         begin op_ok_s = 1'b1; op_code_s = 2'b00; end
            9'h07B:         begin op_ok_s = 1'b1; op_code_s = 2'b01; end
            9'h07C:         begin op_ok_s = 1'b1; op_code_s = 2'b10; end
            9'h05A, 9'h15A: enter_s = 1'b1;
            9'h076:         esc_s = 1'b1;
`ifdef KEY_ENTRY_BACKSPACE_EN
            9'h066:         bksp_s = 1'b1;
`endif
            default:        digit_ok_s = 1'b0;
        endcase
    end

    // Next-state and field update; Esc, timeout and an illegal state code all funnel into clear_s.
    always_comb begin
        state_n      = state_r;
        left_tens_n  = left_tens_r;
        left_ones_n  = left_ones_r;
        right_tens_n = right_tens_r;
        right_ones_n = right_ones_r;
        op_n         = op_r;
        key_err_n    = 1'b0;
        clear_s      = 1'b0;
        if (evt_s && esc_s) begin
            clear_s = 1'b1;
`ifdef KEY_ENTRY_BACKSPACE_EN
        end else if (evt_s && bksp_s) begin
            case (state_r)
                S_L1:    key_err_n = 1'b1;
                S_L2:    begin left_tens_n  = 4'd0;  state_n = S_L1; end
                S_OP:    begin left_ones_n  = 4'd0;  state_n = S_L2; end
                S_R1:    begin op_n         = 2'b11; state_n = S_OP; end
                S_R2:    begin right_tens_n = 4'd0;  state_n = S_R1; end
                S_EQ:    begin right_ones_n = 4'd0;  state_n = S_R2; end
                S_SHOW:  state_n = S_EQ;
                default: clear_s = 1'b1;
            endcase
`endif
        end else if (evt_s) begin
            case (state_r)
                S_L1: if (digit_ok_s) begin left_tens_n = digit_s; state_n = S_L2; end
                      else key_err_n = 1'b1;
                S_L2: if (digit_ok_s) begin left_ones_n = digit_s; state_n = S_OP; end
                      else key_err_n = 1'b1;
                S_OP: if (op_ok_s) begin op_n = op_code_s; state_n = S_R1; end
                      else key_err_n = 1'b1;
                S_R1: if (digit_ok_s) begin right_tens_n = digit_s; state_n = S_R2; end
                      else key_err_n = 1'b1;
                S_R2: if (digit_ok_s) begin right_ones_n = digit_s; state_n = S_EQ; end
                      else key_err_n = 1'b1;
                S_EQ: if (enter_s) state_n = S_SHOW;
                      else key_err_n = 1'b1;
                S_SHOW: if (digit_ok_s) begin
                            left_tens_n  = digit_s; left_ones_n  = 4'd0;
                            right_tens_n = 4'd0;    right_ones_n = 4'd0;
                            op_n = 2'b11; state_n = S_L2;
                        end else if (op_ok_s) begin
                            op_n = op_code_s; right_tens_n = 4'd0; right_ones_n = 4'd0;
                            state_n = S_R1;
                        end else key_err_n = 1'b1;
                default: clear_s = 1'b1;
            endcase
        end else if (timeout_s || state_r == S_UNUSED) begin
            clear_s = 1'b1;
        end else begin
            state_n = state_r;
        end

        if (clear_s) begin
            state_n      = S_L1;
            left_tens_n  = 4'd0;
            left_ones_n  = 4'd0;
            right_tens_n = 4'd0;
            right_ones_n = 4'd0;
            op_n         = 2'b11;
        end else begin
            op_n = op_n;
        end
    end

    // State, field, strobe-history and idle counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= S_L1;
            left_tens_r    <= 4'd0;
            left_ones_r    <= 4'd0;
            right_tens_r   <= 4'd0;
            right_ones_r   <= 4'd0;
            op_r           <= 2'b11;
            result_valid_r <= 1'b0;
            key_err_r      <= 1'b0;
            key_valid_d_r  <= 1'b0;
            idle_cnt_r     <= '0;
        end else begin
            state_r        <= state_n;
            left_tens_r    <= left_tens_n;
            left_ones_r    <= left_ones_n;
            right_tens_r   <= right_tens_n;
            right_ones_r   <= right_ones_n;
            op_r           <= op_n;
            result_valid_r <= (state_n == S_SHOW);
            key_err_r      <= key_err_n;
            key_valid_d_r  <= bus.key_valid;
            if (evt_s || timeout_s) begin
                idle_cnt_r <= '0;
            end else if (idle_cnt_r != CW'(TIMEOUT_CYCLES)) begin
                idle_cnt_r <= idle_cnt_r + CW'(1);
            end else begin
                idle_cnt_r <= idle_cnt_r;
            end
        end
    end

    assign bus.left_tens    = left_tens_r;
    assign bus.left_ones    = left_ones_r;
    assign bus.right_tens   = right_tens_r;
    assign bus.right_ones   = right_ones_r;
    assign bus.op           = op_r;
    assign bus.phase        = state_r;
    assign bus.result_valid = result_valid_r;
    assign bus.key_err      = key_err_r;
endmodule

// File: tb/tb_key_entry_sequencer.sv
// Scoreboard bench: per-cycle expectations from a behavioural model, checked by an independent monitor.
module tb_key_entry_sequencer;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    key_entry_if bus();
    key_entry_sequencer #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int phase; int lt; int lo; int rt; int ro; int op; int rv; int err;
    } exp_t;
    exp_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    int m_phase, m_op, m_idle;
    int m_f[4];
    bit m_kvp;

    int top_row[10] = '{'h045, 'h016, 'h01E, 'h026, 'h025, 'h02E, 'h036, 'h03D, 'h03E, 'h046};
    int keypad[10]  = '{'h070, 'h069, 'h072, 'h07A, 'h06B, 'h073, 'h074, 'h06C, 'h075, 'h07D};
    int op_keys[3]  = '{'h079, 'h07B, 'h07C};

    function automatic int digit_of(input int code);
        for (int i = 0; i < 10; i++)
            if (top_row[i] == code || keypad[i] == code) return i;
        return -1;
    endfunction

    function automatic int op_of(input int code);
        for (int i = 0; i < 3; i++)
            if (op_keys[i] == code) return i;
        return -1;
    endfunction

    // Field slot addressed by an entry phase: L1,L2,R1,R2 -> 0..3.
    function automatic int slot(input int p);
        return (p < 2) ? p : p - 1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_op = 3; m_idle = 0; m_kvp = 1'b0;
        for (int i = 0; i < 4; i++) m_f[i] = 0;
    endtask

    task automatic clear_all();
        m_phase = 0; m_op = 3;
        for (int i = 0; i < 4; i++) m_f[i] = 0;
    endtask

    // Apply the current inputs for one clock: advance the model and queue the expected outputs.
    task automatic step();
        exp_t e;
        int d, o, lc;
        bit evt, err;
        lc  = int'(bus.last_change);
        evt = bus.key_valid && !m_kvp && bus.key_down[bus.last_change];
        m_kvp = bus.key_valid;
        err = 1'b0;
        if (evt) begin
            m_idle = 0;
            d = digit_of(lc);
            o = op_of(lc);
            if (lc == 'h076) clear_all();
            else if (d >= 0 && m_phase inside {0, 1, 3, 4}) begin m_f[slot(m_phase)] = d; m_phase++; end
            else if (d >= 0 && m_phase == 6) begin clear_all(); m_f[0] = d; m_phase = 1; end
            else if (o >= 0 && m_phase inside {2, 6}) begin
                m_op = o;
                if (m_phase == 6) begin m_f[2] = 0; m_f[3] = 0; end
                m_phase = 3;
            end
            else if ((lc == 'h05A || lc == 'h15A) && m_phase == 5) m_phase = 6;
`ifdef KEY_ENTRY_BACKSPACE_EN
            else if (lc == 'h066 && m_phase != 0) begin
                m_phase--;
                if (m_phase == 2) m_op = 3;
                else if (m_phase != 5) m_f[slot(m_phase)] = 0;
            end
`endif
            else err = 1'b1;
        end else if (m_phase != 0 && m_idle + 1 == TO) begin
            clear_all();
            m_idle = 0;
        end else if (m_idle < TO) begin
            m_idle++;
        end
        e.phase = m_phase; e.lt = m_f[0]; e.lo = m_f[1]; e.rt = m_f[2]; e.ro = m_f[3];
        e.op = m_op; e.rv = (m_phase == 6) ? 1 : 0; e.err = err ? 1 : 0;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic press(input logic [8:0] code, input int hold, input bit brk, input int gap);
        bus.last_change = code;
        bus.key_down[code] = 1'b1;
        bus.key_valid = 1'b1;
        repeat (hold) step();
        bus.key_valid = 1'b0;
        step();
        bus.key_down[code] = 1'b0;
        if (brk) begin
            bus.key_valid = 1'b1;
            step();
            bus.key_valid = 1'b0;
            step();
        end
        repeat (gap) step();
    endtask

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_reset_values();
        check("reset_left_tens", int'(bus.left_tens), 0);
        check("reset_left_ones", int'(bus.left_ones), 0);
        check("reset_right_tens", int'(bus.right_tens), 0);
        check("reset_right_ones", int'(bus.right_ones), 0);
        check("reset_op", int'(bus.op), 3);
        check("reset_phase", int'(bus.phase), 0);
        check("reset_result_valid", int'(bus.result_valid), 0);
        check("reset_key_err", int'(bus.key_err), 0);
    endtask

    // Monitor: one queued expectation per clock, compared just after the active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (int'(bus.phase) != e.phase || int'(bus.left_tens) != e.lt ||
                    int'(bus.left_ones) != e.lo || int'(bus.right_tens) != e.rt ||
                    int'(bus.right_ones) != e.ro || int'(bus.op) != e.op ||
                    int'(bus.result_valid) != e.rv || int'(bus.key_err) != e.err) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got ph=%0d L=%0d%0d R=%0d%0d op=%0d rv=%0d err=%0d, expected ph=%0d L=%0d%0d R=%0d%0d op=%0d rv=%0d err=%0d",
                             $time, bus.phase, bus.left_tens, bus.left_ones, bus.right_tens,
                             bus.right_ones, bus.op, bus.result_valid, bus.key_err,
                             e.phase, e.lt, e.lo, e.rt, e.ro, e.op, e.rv, e.err);
                end
            end
        end
    end

    initial begin
        int r, code, gap;
        bus.last_change = 9'd0;
        bus.key_down    = '0;
        bus.key_valid   = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_values();
        rst = 1'b1;
        model_reset();

        // Full calculation 12 + 34, Enter.
        press(9'h016, 1, 1'b1, 1); press(9'h01E, 1, 1'b1, 1); press(9'h079, 1, 1'b1, 1);
        press(9'h026, 1, 1'b1, 1); press(9'h025, 1, 1'b1, 1); press(9'h05A, 1, 1'b1, 1);
        check("seq_left_tens", int'(bus.left_tens), 1);
        check("seq_left_ones", int'(bus.left_ones), 2);
        check("seq_op", int'(bus.op), 0);
        check("seq_right_tens", int'(bus.right_tens), 3);
        check("seq_right_ones", int'(bus.right_ones), 4);
        check("seq_phase", int'(bus.phase), 6);
        check("seq_result_valid", int'(bus.result_valid), 1);

        // Held key with a long strobe accepts exactly one digit.
        press(9'h076, 1, 1'b0, 1);
        press(9'h016, 12, 1'b1, 1);
        check("held_phase", int'(bus.phase), 1);
        check("held_left_tens", int'(bus.left_tens), 1);

        // Operator in S_L1 is rejected with a one-cycle key_err.
        press(9'h076, 1, 1'b0, 1);
        bus.last_change = 9'h079; bus.key_down[9'h079] = 1'b1; bus.key_valid = 1'b1;
        step();
        check("err_pulse_high", int'(bus.key_err), 1);
        bus.key_valid = 1'b0;
        step();
        bus.key_down[9'h079] = 1'b0;
        check("err_pulse_low", int'(bus.key_err), 0);
        check("err_phase", int'(bus.phase), 0);

        // Esc in S_R2 clears everything.
        press(9'h016, 1, 1'b0, 0); press(9'h01E, 1, 1'b0, 0);
        press(9'h07C, 1, 1'b0, 0); press(9'h026, 1, 1'b0, 0);
        check("r2_phase", int'(bus.phase), 4);
        press(9'h076, 1, 1'b0, 0);
        check("esc_phase", int'(bus.phase), 0);
        check("esc_op", int'(bus.op), 3);
        check("esc_left_tens", int'(bus.left_tens), 0);
        check("esc_right_tens", int'(bus.right_tens), 0);

        // Timeout: clear on the 16th idle cycle; an evt on that cycle wins.
        press(9'h045, 1, 1'b0, 0);
        repeat (14) step();
        check("to_before_phase", int'(bus.phase), 1);
        step();
        check("to_after_phase", int'(bus.phase), 0);
        press(9'h045, 1, 1'b0, 0);
        repeat (14) step();
        press(9'h016, 1, 1'b0, 0);
        check("to_evt_wins_phase", int'(bus.phase), 2);
        check("to_evt_wins_left_ones", int'(bus.left_ones), 1);

        // Backspace after two digits.
        press(9'h076, 1, 1'b0, 0);
        press(9'h016, 1, 1'b0, 0); press(9'h01E, 1, 1'b0, 0); press(9'h066, 1, 1'b0, 0);
`ifdef KEY_ENTRY_BACKSPACE_EN
        check("bksp_phase", int'(bus.phase), 1);
        check("bksp_left_ones", int'(bus.left_ones), 0);
        check("bksp_left_tens", int'(bus.left_tens), 1);
`else
        check("bksp_phase", int'(bus.phase), 2);
        check("bksp_left_ones", int'(bus.left_ones), 2);
`endif

        // Asynchronous reset mid-sequence.
        press(9'h079, 1, 1'b0, 0); press(9'h03E, 1, 1'b0, 0);
        rst = 1'b0;
        #1;
        check_reset_values();
        bus.key_valid = 1'b0;
        bus.key_down  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Randomised key traffic.
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: code = top_row[$urandom_range(0, 9)];
                4, 5:       code = keypad[$urandom_range(0, 9)];
                6:          code = op_keys[$urandom_range(0, 2)];
                7:          code = ($urandom_range(0, 1) == 0) ? 'h05A : 'h15A;
                8:          code = ($urandom_range(0, 3) == 0) ? 'h076 : top_row[$urandom_range(0, 9)];
                default:    code = ($urandom_range(0, 1) == 0) ? 'h066 : int'($urandom_range(0, 511));
            endcase
            gap = ($urandom_range(0, 19) == 0) ? 17 : int'($urandom_range(0, 2));
            press(9'(code), int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), gap);
        end

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/key_entry_sequencer.md
Name: key_entry_sequencer

Overview:
- Sits between the PS/2 keyboard decoder and the two-digit calculator datapath.
- Turns raw make events into an operand/operator entry sequence: left two-digit operand, operator, right two-digit operand, then Enter.
- Outputs registered BCD digits, an operator code and a phase code for the calculator and the 7-segment display mux.
- Replaces the separate one-pulse generators, FSM and per-digit memories with one sequential block.

Parameters:
- TIMEOUT_CYCLES, 0, idle cycles with no accepted key before an automatic clear to S_L1; 0 disables the timeout.

Ports:
- clk  input  1  system clock (100 MHz)
- rst  input  1  reset, asynchronous, active-low
- last_change  input  9  most recent scan code from the decoder; bit 8 = E0-extended
- key_down  input  512  per-scan-code held vector from the decoder
- key_valid  input  1  decoder strobe, high for one or more cycles per completed code
- left_tens  output  4  left operand tens digit, BCD
- left_ones  output  4  left operand ones digit, BCD
- right_tens  output  4  right operand tens digit, BCD
- right_ones  output  4  right operand ones digit, BCD
- op  output  2  operator: 00 add, 01 subtract, 10 multiply, 11 none
- phase  output  3  current state code, see Behaviour
- result_valid  output  1  high while in S_SHOW
- key_err  output  1  one-cycle pulse when a key is rejected

Behaviour:
- Reset (rst low, async): all digit outputs 0, op=11, phase=S_L1, result_valid=0, key_err=0, idle counter 0.
- Event detect:
  - key_valid_d is key_valid registered.
  - evt = key_valid & ~key_valid_d & key_down[last_change].
  - Break codes and held-key repeats never produce evt.
  - At most one evt per clock.
- Key classes, decoded combinationally from last_change:
  - Digits, top row: 045,016,01E,026,025,02E,036,03D,03E,046 = 0..9.
  - Digits, keypad: 070,069,072,07A,06B,073,074,06C,075,07D = 0..9.
  - Operators: 079 = add, 07B = subtract, 07C = multiply.
  - Enter: 05A or 15A. Clear: 076 (Esc).
  - Anything else is class NONE.
- All outputs update on the clock edge after the evt cycle (1-cycle latency). key_err asserts in that same cycle for exactly one clock.
- States and phase codes: S_L1=0, S_L2=1, S_OP=2, S_R1=3, S_R2=4, S_EQ=5, S_SHOW=6. Code 7 is unused and recovers to S_L1.
- Transitions on evt:
  - S_L1 + digit: left_tens <= d, go S_L2.
  - S_L2 + digit: left_ones <= d, go S_OP.
  - S_OP + operator: op <= code, go S_R1.
  - S_R1 + digit: right_tens <= d, go S_R2.
  - S_R2 + digit: right_ones <= d, go S_EQ.
  - S_EQ + Enter: go S_SHOW, result_valid <= 1.
  - S_SHOW + digit: clear all fields, left_tens <= d, op <= 11, go S_L2 (new calculation).
  - S_SHOW + operator: keep the left fields, op <= code, clear right fields, go S_R1.
  - Any state + Esc: clear all fields, op <= 11, go S_L1, no key_err.
  - Any other class/state pairing (including NONE): state and fields unchanged, key_err pulses.
- Idle timeout (TIMEOUT_CYCLES > 0):
  - The counter resets on every evt, otherwise increments and saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES in any state other than S_L1: perform the Esc action and reset the counter.
  - If evt and timeout coincide, evt wins and the counter resets.
- Reset asserted mid-sequence: immediate return to reset values; no partial field retained.

Optional Feature:
- Macro: KEY_ENTRY_BACKSPACE_EN.
- Defined: scan code 066 (Backspace) steps back one phase and clears the field entered last:
  - S_L2 -> S_L1, left_tens=0.
  - S_OP -> S_L2, left_ones=0.
  - S_R1 -> S_OP, op=11.
  - S_R2 -> S_R1, right_tens=0.
  - S_EQ -> S_R2, right_ones=0.
  - S_SHOW -> S_EQ, result_valid=0.
  - In S_L1: no change, key_err pulses.
- Not defined: 066 is class NONE and pulses key_err in every state.

Test Plan:
- Release rst after 5 clocks -> all digits 0, op=11, phase=0, result_valid=0.
- Keys 016,01E,079,026,025,05A, each a single key_valid pulse with key_down set -> left=1,2; op=00; right=3,4; phase=6; result_valid=1.
- Key 016 held: key_valid high for 4 cycles and repeated 3 times with break in between only once -> exactly one digit accepted; break code produces no evt.
- In S_L1 press 079 -> key_err one-cycle pulse, phase stays 0; in S_R2 press 076 -> all fields 0, op=11, phase=0.
- TIMEOUT_CYCLES=16: enter 045 then idle 16 cycles -> phase returns to 0 on cycle 16; an evt on cycle 16 wins and no clear occurs.
- With KEY_ENTRY_BACKSPACE_EN: 016,01E,066 -> phase=1, left_ones=0, left_tens=1. Without it: the same sequence -> key_err pulses, phase=2.
